// File: rtl/dds_controller_multitone.sv
// Multi-tone DDS parameter controller: per-tone shadow/active register banks,
// atomic masked commit, and per-tone linear frequency ramps.
module dds_controller_multitone #(
    parameter int NUM_TONES   = 4,
    parameter int FREQ_WIDTH  = 48,
    parameter int AMP_WIDTH   = 14,
    parameter int PHASE_WIDTH = 14
) (
    input  logic                             CLK100MHZ,
    input  logic                             reset,
    input  logic                             cmd_valid,
    input  logic [127:0]                     cmd_data,
    output logic [NUM_TONES*FREQ_WIDTH-1:0]  freq,
    output logic [NUM_TONES*AMP_WIDTH-1:0]   amp,
    output logic [NUM_TONES*PHASE_WIDTH-1:0] phase,
    output logic [NUM_TONES*14-1:0]          amp_offset,
    output logic [63:0]                      time_offset,
    output logic [63:0]                      timestamp,
    output logic [NUM_TONES-1:0]             ramp_active,
    output logic                             cmd_error
);

    typedef enum logic {
        IDLE,
        RAMP
    } ramp_st_e;

    localparam logic [3:0] OP_SET_FREQ   = 4'h0;
    localparam logic [3:0] OP_SET_AP     = 4'h1;
    localparam logic [3:0] OP_SET_AOFS   = 4'h2;
    localparam logic [3:0] OP_SET_TOFS   = 4'h3;
    localparam logic [3:0] OP_COMMIT     = 4'h4;
    localparam logic [3:0] OP_RAMP_START = 4'h5;
    localparam logic [3:0] OP_RAMP_ABORT = 4'h6;

    logic [FREQ_WIDTH-1:0]  freq_sh_q  [NUM_TONES];
    logic [FREQ_WIDTH-1:0]  freq_sh_d  [NUM_TONES];
    logic [FREQ_WIDTH-1:0]  freq_act_q [NUM_TONES];
    logic [FREQ_WIDTH-1:0]  freq_act_d [NUM_TONES];
    logic [AMP_WIDTH-1:0]   amp_sh_q   [NUM_TONES];
    logic [AMP_WIDTH-1:0]   amp_sh_d   [NUM_TONES];
    logic [AMP_WIDTH-1:0]   amp_act_q  [NUM_TONES];
    logic [AMP_WIDTH-1:0]   amp_act_d  [NUM_TONES];
    logic [PHASE_WIDTH-1:0] ph_sh_q    [NUM_TONES];
    logic [PHASE_WIDTH-1:0] ph_sh_d    [NUM_TONES];
    logic [PHASE_WIDTH-1:0] ph_act_q   [NUM_TONES];
    logic [PHASE_WIDTH-1:0] ph_act_d   [NUM_TONES];
    logic [13:0]            aofs_sh_q  [NUM_TONES];
    logic [13:0]            aofs_sh_d  [NUM_TONES];
    logic [13:0]            aofs_act_q [NUM_TONES];
    logic [13:0]            aofs_act_d [NUM_TONES];
    logic [FREQ_WIDTH-1:0]  step_q     [NUM_TONES];
    logic [FREQ_WIDTH-1:0]  step_d     [NUM_TONES];
    logic [23:0]            cnt_q      [NUM_TONES];
    logic [23:0]            cnt_d      [NUM_TONES];
    ramp_st_e               st_q       [NUM_TONES];
    ramp_st_e               st_d       [NUM_TONES];

    logic [63:0] time_offset_q, time_offset_d;
    logic [63:0] timestamp_q, timestamp_d;
    logic        cmd_error_q, cmd_error_d;

    logic [3:0]            cmd_op;
    logic [3:0]            cmd_idx;
    logic [55:0]           payload;
    logic [23:0]           ramp_cnt;
    logic [FREQ_WIDTH-1:0] ramp_step;
    logic                  idx_ok;

    assign cmd_op    = cmd_data[63:60];
    assign cmd_idx   = cmd_data[59:56];
    assign payload   = cmd_data[55:0];
    assign ramp_cnt  = payload[55:32];
    assign ramp_step = FREQ_WIDTH'($signed(payload[31:0]));
    assign idx_ok    = ({1'b0, cmd_idx} < 5'(NUM_TONES));

    always_comb begin
        freq_sh_d     = freq_sh_q;
        freq_act_d    = freq_act_q;
        amp_sh_d      = amp_sh_q;
        amp_act_d     = amp_act_q;
        ph_sh_d       = ph_sh_q;
        ph_act_d      = ph_act_q;
        aofs_sh_d     = aofs_sh_q;
        aofs_act_d    = aofs_act_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        st_d          = st_q;
        time_offset_d = time_offset_q;
        timestamp_d   = timestamp_q;
        cmd_error_d   = 1'b0;

        // Ramps advance every edge; commands below may override this edge's step.
        for (int t = 0; t < NUM_TONES; t++) begin
            if (st_q[t] == RAMP) begin
                freq_act_d[t] = freq_act_q[t] + step_q[t];
                cnt_d[t]      = cnt_q[t] - 24'd1;
                if (cnt_q[t] == 24'd1) st_d[t] = IDLE;
            end
        end

        if (cmd_valid) begin
            case (cmd_op)
                OP_SET_FREQ, OP_SET_AP, OP_SET_AOFS,
                OP_RAMP_START, OP_RAMP_ABORT: begin
                    if (!idx_ok) cmd_error_d = 1'b1;
                    for (int t = 0; t < NUM_TONES; t++) begin
                        if (cmd_idx == 4'(t)) begin
                            case (cmd_op)
                                OP_SET_FREQ:
                                    freq_sh_d[t] = payload[FREQ_WIDTH-1:0];
                                OP_SET_AP: begin
                                    amp_sh_d[t] = payload[14 +: AMP_WIDTH];
                                    ph_sh_d[t]  = payload[0 +: PHASE_WIDTH];
                                end
                                OP_SET_AOFS:
                                    aofs_sh_d[t] = payload[13:0];
                                OP_RAMP_START: begin
                                    if (ramp_cnt != 24'd0) begin
                                        step_d[t]     = ramp_step;
                                        cnt_d[t]      = ramp_cnt;
                                        st_d[t]       = RAMP;
                                        freq_act_d[t] = freq_act_q[t];
                                    end
                                end
                                default: begin
                                    st_d[t]       = IDLE;
                                    freq_act_d[t] = freq_act_q[t];
                                end
                            endcase
                        end
                    end
                end
                OP_SET_TOFS: time_offset_d = {8'h0, payload};
                OP_COMMIT: begin
                    timestamp_d = cmd_data[127:64];
                    for (int t = 0; t < NUM_TONES; t++) begin
                        if (payload[t]) begin
                            freq_act_d[t] = freq_sh_q[t];
                            amp_act_d[t]  = amp_sh_q[t];
                            ph_act_d[t]   = ph_sh_q[t];
                            aofs_act_d[t] = aofs_sh_q[t];
                            st_d[t]       = IDLE;
                        end
                    end
                end
                default: cmd_error_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int t = 0; t < NUM_TONES; t++) begin
                freq_sh_q[t]  <= '0;
                freq_act_q[t] <= '0;
                amp_sh_q[t]   <= '0;
                amp_act_q[t]  <= '0;
                ph_sh_q[t]    <= '0;
                ph_act_q[t]   <= '0;
                aofs_sh_q[t]  <= '0;
                aofs_act_q[t] <= '0;
                step_q[t]     <= '0;
                cnt_q[t]      <= '0;
                st_q[t]       <= IDLE;
            end
            time_offset_q <= '0;
            timestamp_q   <= '0;
            cmd_error_q   <= 1'b0;
        end else begin
            freq_sh_q     <= freq_sh_d;
            freq_act_q    <= freq_act_d;
            amp_sh_q      <= amp_sh_d;
            amp_act_q     <= amp_act_d;
            ph_sh_q       <= ph_sh_d;
            ph_act_q      <= ph_act_d;
            aofs_sh_q     <= aofs_sh_d;
            aofs_act_q    <= aofs_act_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            st_q          <= st_d;
            time_offset_q <= time_offset_d;
            timestamp_q   <= timestamp_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

    for (genvar t = 0; t < NUM_TONES; t++) begin : g_out
        assign freq[t*FREQ_WIDTH +: FREQ_WIDTH]    = freq_act_q[t];
        assign amp[t*AMP_WIDTH +: AMP_WIDTH]       = amp_act_q[t];
        assign phase[t*PHASE_WIDTH +: PHASE_WIDTH] = ph_act_q[t];
        assign amp_offset[t*14 +: 14]              = aofs_act_q[t];
        assign ramp_active[t]                      = (st_q[t] == RAMP);
    end

    assign time_offset = time_offset_q;
    assign timestamp   = timestamp_q;
    assign cmd_error   = cmd_error_q;

endmodule

// File: doc/dds_controller_multitone.md
DDS_CONTROLLER_MULTITONE -- requirements
Module: dds_controller_multitone

Interface
REQ-001 Parameter NUM_TONES, default 4, number of independent tone channels; legal range 1..16.
REQ-002 Parameter FREQ_WIDTH, default 48, per-tone frequency word width; legal range 32..48.
REQ-003 Parameter AMP_WIDTH, default 14, per-tone unsigned amplitude width; legal range 1..14.
REQ-004 Parameter PHASE_WIDTH, default 14, per-tone phase width; legal range 1..14.
REQ-005 CLK100MHZ  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 cmd_valid  input  1  one-cycle strobe: cmd_data is a decoded command.
REQ-008 cmd_data  input  128  [127:64] timestamp; [63:60] opcode; [59:56] tone index; [55:0] payload.
REQ-009 freq  output  NUM_TONES*FREQ_WIDTH  active frequency words, tone t at [t*FREQ_WIDTH +: FREQ_WIDTH].
REQ-010 amp  output  NUM_TONES*AMP_WIDTH  active amplitudes, same packing.
REQ-011 phase  output  NUM_TONES*PHASE_WIDTH  active phases, same packing.
REQ-012 amp_offset  output  NUM_TONES*14  active amplitude offsets, same packing.
REQ-013 time_offset  output  64  global time offset.
REQ-014 timestamp  output  64  timestamp of the last COMMIT.
REQ-015 ramp_active  output  NUM_TONES  bit t high while tone t is ramping.
REQ-016 cmd_error  output  1  one-cycle pulse on a rejected command.

Function
REQ-017 Each tone SHALL hold a shadow and an active copy of freq, amp, phase and amp_offset; outputs SHALL show active copies only.
REQ-018 All commands SHALL take effect at the clock edge after the cmd_valid cycle (latency 1); cmd_valid low SHALL change nothing except ramps.
REQ-019 Opcode 0x0 SET_FREQ: shadow freq[t] <= payload[FREQ_WIDTH-1:0].
REQ-020 Opcode 0x1 SET_AMP_PHASE: shadow amp[t] <= payload[14 +: AMP_WIDTH]; shadow phase[t] <= payload[0 +: PHASE_WIDTH].
REQ-021 Opcode 0x2 SET_AMP_OFFSET: shadow amp_offset[t] <= payload[13:0].
REQ-022 Opcode 0x3 SET_TIME_OFFSET: time_offset <= {8'h0, payload}, applied directly without a shadow; tone index ignored.
REQ-023 Opcode 0x4 COMMIT: for every t with payload[t]=1, active <= shadow for all four fields atomically in one edge; timestamp <= cmd_data[127:64]; tone index ignored; payload bits >= NUM_TONES ignored.
REQ-024 Opcode 0x5 RAMP_START: tone t loads step = payload[31:0] (signed, sign-extended/truncated to FREQ_WIDTH) and count = payload[55:32]; ramp_active[t] <= 1 if count != 0.
REQ-025 Per-tone ramp FSM, states IDLE and RAMP: IDLE->RAMP on RAMP_START with count != 0; in RAMP, each edge SHALL set active freq[t] += step and count -= 1; RAMP->IDLE on the edge where count reaches 0; exactly count increments occur, the first at the edge after ramp_active rises.
REQ-026 Ramp arithmetic SHALL wrap modulo 2^FREQ_WIDTH; no saturation; shadow freq SHALL be unaffected by ramping.
REQ-027 Opcode 0x6 RAMP_ABORT: tone t returns to IDLE next edge; active freq holds its current value.
REQ-028 RAMP_START with count = 0 SHALL be a no-op and not an error.
REQ-029 RAMP_START on a tone already in RAMP SHALL restart it with the new step and count.
REQ-030 COMMIT that includes a ramping tone SHALL load shadow freq, abort the ramp (ramp_active low next edge) and override that edge's increment.
REQ-031 Opcodes 0x7..0xF, and tone index >= NUM_TONES on opcodes 0x0, 0x1, 0x2, 0x5 and 0x6, SHALL be ignored, with cmd_error = 1 on the following cycle only.
REQ-032 Ramps on different tones SHALL run concurrently and independently.

Reset
REQ-033 While reset is high at an edge, all shadow and active fields, time_offset, timestamp, ramp counters, ramp_active and cmd_error SHALL be 0 and all FSMs IDLE; reset SHALL take priority over cmd_valid and over an in-progress ramp.
REQ-034 Reset asserted mid-ramp SHALL leave freq = 0 after deassertion, with no further increments.

Verification
REQ-035 SET_FREQ t1=0x1234, then COMMIT mask 0b0010 with ts=100: freq tone1 = 0x1234 one cycle after the COMMIT, not earlier; timestamp = 100; other tones stay 0.
REQ-036 Active freq t0=10, RAMP_START step=+5 count=3: ramp_active high for 3 cycles; freq reads 15, 20, 25, then holds 25.
REQ-037 Active freq t0=0, step=-1 (0xFFFFFFFF), count=1, FREQ_WIDTH=48: freq = 0xFFFF_FFFF_FFFF.
REQ-038 Tone2 ramping, COMMIT mask 0b0100 with shadow freq 7: freq = 7 next edge; ramp_active[2] = 0.
REQ-039 Opcode 0x9 and tone index 5 with NUM_TONES=4: cmd_error pulses one cycle per command; no output changes.
REQ-040 Reset pulsed at cycle 2 of a count=10 ramp: all outputs 0; ramp_active = 0 thereafter.
